data_ram: RTL and testbench
===========================

// Module: data_ram
// PURPOSE
//   Data-memory responder on the CPU MEM-stage load/store port. The CPU drives a request
//     (ce/we/addr/sel/data), and this block answers with a one-cycle ack after a
//     configurable number of wait states.
//   Provides word-addressed storage with per-byte write enables. The SoC bench places it
//     beside the instruction ROM and preloads it with $readmemh on the array `mem`.
// PARAMETERS
//   DEPTH_LOG2   10  log2 of word count (default 1024 x 32-bit words = 4 KiB)
//   WAIT_CYCLES  1   wait states inserted between accept and ack; legal range 0..15
// PORTS
//   clk      in   1   system clock; all logic on posedge
//   rst      in   1   synchronous reset, active-high (`RstEnable); priority over all inputs
//   ce_i     in   1   request strobe; held high by CPU until ack_o
//   we_i     in   1   1 = write, 0 = read
//   addr_i   in   32  byte address; word index = addr_i[DEPTH_LOG2+1:2]
//   sel_i    in   4   byte enables for writes; bit i -> data bits [8i+7:8i]
//   data_i   in   32  write data
//   data_o   out  32  read data; valid while ack_o=1, held until next read ack
//   ack_o    out  1   transaction complete, high exactly one cycle per request
//   busy_o   out  1   1 while a request is in flight (state != IDLE)
// BEHAVIOUR
//   Reset: state=IDLE, cnt=0, ack_o=0, data_o=0, busy_o=0. `mem` is not cleared.
//   FSM states:
//     IDLE: ce_i=1 at posedge -> latch we/addr/sel/data (request accepted at cycle T).
//           Next state is WAIT with cnt=WAIT_CYCLES-1, or ACK if WAIT_CYCLES=0.
//     WAIT: cnt=0 -> ACK; otherwise cnt-=1. Inputs are ignored; latched copies are used.
//     ACK:  ack_o=1 for this cycle only; unconditional -> IDLE.
//   Latency: ack_o is high during cycle T+1+WAIT_CYCLES. All outputs are registered.
//   Write: `mem` is updated at the edge entering ACK, so it is visible to a read accepted
//     next. Byte lanes with sel=0 are unchanged. sel=4'b0000 still acks with no change.
//   Read: data_o loads the full word at the edge entering ACK; sel_i is ignored for reads.
//     data_o is unchanged on write acks.
//   Requests are accepted only in IDLE. ce_i held high during ACK is not a new request.
//     Back-to-back requests therefore have at least one IDLE cycle between acks.
//   ce_i dropping mid-transaction does not cancel it; the ack still occurs.
//   Addressing: addr_i[1:0] are ignored (no misalignment fault). Bits above
//     DEPTH_LOG2+1 are ignored, so addresses wrap/alias modulo 4<<DEPTH_LOG2 bytes.
//   Reset mid-transaction aborts it: no ack, and a pending write is NOT performed if rst=1
//     at or before the edge that would enter ACK.
//   rst and ce_i high together: reset wins; the request is dropped.
// TESTING
//   1. rst=1 for 2 cycles with ce_i=1 -> ack_o=0, data_o=0, busy_o=0 throughout;
//      no request is accepted.
//   2. WAIT=1: write 0xDEADBEEF @0x10, sel=F at T -> busy_o=1 at T+1..T+2, ack at T+2;
//      read @0x10 -> data_o=0xDEADBEEF with ack.
//   3. Write 0x0000AB00 @0x10 with sel=4'b0010 -> subsequent read returns 0xDEADABEF.
//   4. DEPTH_LOG2=10: reads @0x13 and @0x1010 both return word @0x10 (0xDEADABEF).
//   5. WAIT=3: write 0x12345678 @0x20 at T, rst=1 at T+2 -> no ack ever;
//      read @0x20 after reset returns the preloaded value.
//   6. WAIT=0: ce_i held high, alternating write/read @0x40 -> ack every 2nd cycle;
//      each read returns the last written word.

Source files
------------

// File: rtl/data_ram.sv
// Data-memory responder for the CPU MEM-stage load/store port.
// Word-addressed storage with per-byte write enables. Each request gets a
// one-cycle ack after WAIT_CYCLES wait states. All outputs are registered.
module data_ram #(
    parameter int unsigned DEPTH_LOG2  = 10,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [3:0]  sel_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        ack_o,
    output logic        busy_o
);

    localparam int unsigned Words = 1 << DEPTH_LOG2;
    // Wait-state counter preload; unused when there are no wait states.
    localparam logic [3:0] LoadCnt = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StWait, StAck} state_e;

    state_e                  state_q;
    logic [3:0]              cnt_q;
    logic                    we_q;
    logic [DEPTH_LOG2-1:0]   idx_q;
    logic [3:0]              sel_q;
    logic [31:0]             wdata_q;
    logic [31:0]             data_q;
    logic                    ack_q;
    logic                    busy_q;

    // Storage; preloaded externally by the SoC bench, never cleared by reset.
    logic [31:0] mem [Words];

    logic                    enter_ack;
    logic                    eff_we;
    logic [DEPTH_LOG2-1:0]   eff_idx;
    logic [3:0]              eff_sel;
    logic [31:0]             eff_data;

    // Byte-offset bits and bits above the array size are deliberately ignored.
    logic unused_addr;
    assign unused_addr = ^{addr_i[31:DEPTH_LOG2+2], addr_i[1:0]};

    // Decide whether this edge enters ACK, and which request fields apply.
    // With zero wait states the request goes straight from IDLE to ACK, so the
    // live inputs are used; otherwise the latched copies are.
    always_comb begin
        enter_ack = 1'b0;
        eff_we    = we_q;
        eff_idx   = idx_q;
        eff_sel   = sel_q;
        eff_data  = wdata_q;
        if (state_q == StIdle) begin
            eff_we    = we_i;
            eff_idx   = addr_i[DEPTH_LOG2+1:2];
            eff_sel   = sel_i;
            eff_data  = data_i;
            enter_ack = ce_i && (WAIT_CYCLES == 0);
        end else if (state_q == StWait) begin
            enter_ack = (cnt_q == 4'd0);
        end
    end

    // Request FSM with registered ack/busy/read-data outputs; reset has priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            idx_q   <= '0;
            sel_q   <= 4'd0;
            wdata_q <= 32'd0;
            data_q  <= 32'd0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            ack_q <= enter_ack;
            if (enter_ack && !eff_we) begin
                data_q <= mem[eff_idx];
            end
            unique case (state_q)
                StIdle: begin
                    busy_q <= ce_i;
                    if (ce_i) begin
                        we_q    <= we_i;
                        idx_q   <= addr_i[DEPTH_LOG2+1:2];
                        sel_q   <= sel_i;
                        wdata_q <= data_i;
                        if (WAIT_CYCLES == 0) begin
                            state_q <= StAck;
                        end else begin
                            state_q <= StWait;
                            cnt_q   <= LoadCnt;
                        end
                    end
                end
                StWait: begin
                    busy_q <= 1'b1;
                    if (cnt_q == 4'd0) begin
                        state_q <= StAck;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                StAck: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Byte-masked write on the edge entering ACK; suppressed while in reset.
    always_ff @(posedge clk) begin
        if (!rst && enter_ack && eff_we) begin
            for (int b = 0; b < 4; b++) begin
                if (eff_sel[b]) begin
                    mem[eff_idx][8*b +: 8] <= eff_data[8*b +: 8];
                end
            end
        end
    end

    assign data_o = data_q;
    assign ack_o  = ack_q;
    assign busy_o = busy_q;

endmodule

// File: tb/tb_data_ram.sv
// Directed bench for data_ram: three instances (1, 3 and 0 wait states) on a
// shared request bus; each section checks only the instance it targets.
module tb_data_ram;

    logic        clk;
    logic        rst;
    logic        ce;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;

    logic [31:0] dout_w1, dout_w3, dout_w0;
    logic        ack_w1, ack_w3, ack_w0;
    logic        busy_w1, busy_w3, busy_w0;

    int n_vec;
    int n_err;

    data_ram #(.DEPTH_LOG2(10), .WAIT_CYCLES(1)) u_w1 (
        .clk(clk), .rst(rst), .ce_i(ce), .we_i(we), .addr_i(addr), .sel_i(sel),
        .data_i(wdata), .data_o(dout_w1), .ack_o(ack_w1), .busy_o(busy_w1)
    );
    data_ram #(.DEPTH_LOG2(10), .WAIT_CYCLES(3)) u_w3 (
        .clk(clk), .rst(rst), .ce_i(ce), .we_i(we), .addr_i(addr), .sel_i(sel),
        .data_i(wdata), .data_o(dout_w3), .ack_o(ack_w3), .busy_o(busy_w3)
    );
    data_ram #(.DEPTH_LOG2(10), .WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .rst(rst), .ce_i(ce), .we_i(we), .addr_i(addr), .sel_i(sel),
        .data_i(wdata), .data_o(dout_w0), .ack_o(ack_w0), .busy_o(busy_w0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic ack_of(input int w);
        case (w)
            1:       return ack_w1;
            3:       return ack_w3;
            default: return ack_w0;
        endcase
    endfunction

    function automatic logic busy_of(input int w);
        case (w)
            1:       return busy_w1;
            3:       return busy_w3;
            default: return busy_w0;
        endcase
    endfunction

    function automatic logic [31:0] dout_of(input int w);
        case (w)
            1:       return dout_w1;
            3:       return dout_w3;
            default: return dout_w0;
        endcase
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Issue one request, hold ce until the target instance acks, and check
    // latency plus busy. Returns data_o as seen during the ack cycle.
    task automatic run_req(input int w, input logic wr, input logic [31:0] a,
                           input logic [3:0] s, input logic [31:0] d,
                           input string tag, output logic [31:0] rdata);
        int lat;
        logic got;
        @(negedge clk);
        ce = 1'b1; we = wr; addr = a; sel = s; wdata = d;
        lat = 0;
        got = 1'b0;
        rdata = 32'd0;
        while (!got && lat < 40) begin
            @(negedge clk);
            lat++;
            if (lat == 1) check({tag, " busy@1"}, 32'(busy_of(w)), 32'd1);
            if (ack_of(w)) begin
                got = 1'b1;
                rdata = dout_of(w);
                check({tag, " busy@ack"}, 32'(busy_of(w)), 32'd1);
                check({tag, " latency"}, 32'(lat), 32'(1 + w));
            end
        end
        ce = 1'b0;
        if (!got) check({tag, " ack timeout"}, 32'd0, 32'd1);
    endtask

    logic [31:0] rd;
    logic [31:0] wv [3];

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b1; ce = 1'b1; we = 1'b0; addr = 32'h10; sel = 4'hF; wdata = 32'd0;

        // Reset with ce asserted: nothing may start.
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check("rst ack_w1", 32'(ack_w1), 32'd0);
            check("rst busy_w1", 32'(busy_w1), 32'd0);
            check("rst data_w1", dout_w1, 32'd0);
            check("rst ack_w3", 32'(ack_w3), 32'd0);
            check("rst busy_w0", 32'(busy_w0), 32'd0);
            check("rst data_w0", dout_w0, 32'd0);
        end
        rst = 1'b0; ce = 1'b0;
        @(negedge clk);
        check("post-rst busy_w1", 32'(busy_w1), 32'd0);
        check("post-rst ack_w1", 32'(ack_w1), 32'd0);
        @(negedge clk);
        check("post-rst busy_w1 idle", 32'(busy_w1), 32'd0);

        // Full write and read back, one wait state.
        run_req(1, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, "w1 wr10", rd);
        @(negedge clk);
        check("w1 busy after ack", 32'(busy_w1), 32'd0);
        check("w1 ack one cycle", 32'(ack_w1), 32'd0);
        idle(3);
        run_req(1, 1'b0, 32'h10, 4'h0, 32'd0, "w1 rd10", rd);
        check("w1 rd10 data", rd, 32'hDEADBEEF);
        idle(3);
        check("w1 data held", dout_w1, 32'hDEADBEEF);

        // Single-lane write; data_o must not change on a write ack.
        run_req(1, 1'b1, 32'h10, 4'b0010, 32'h0000AB00, "w1 wr lane1", rd);
        check("w1 data on write ack", rd, 32'hDEADBEEF);
        idle(3);
        run_req(1, 1'b0, 32'h10, 4'hF, 32'd0, "w1 rd lane1", rd);
        check("w1 lane1 merge", rd, 32'hDEADABEF);
        idle(3);

        // Empty byte mask still acks and leaves the word alone.
        run_req(1, 1'b1, 32'h10, 4'b0000, 32'hFFFFFFFF, "w1 wr sel0", rd);
        idle(3);

        // Low bits and upper address bits alias onto the same word.
        run_req(1, 1'b0, 32'h13, 4'h0, 32'd0, "w1 rd13", rd);
        check("w1 rd13 data", rd, 32'hDEADABEF);
        idle(3);
        run_req(1, 1'b0, 32'h1010, 4'h0, 32'd0, "w1 rd1010", rd);
        check("w1 rd1010 data", rd, 32'hDEADABEF);
        idle(6);

        // Three wait states: establish a known word, then abort a write by reset.
        run_req(3, 1'b1, 32'h20, 4'hF, 32'hCAFEF00D, "w3 wr20", rd);
        idle(6);
        @(negedge clk);
        ce = 1'b1; we = 1'b1; addr = 32'h20; sel = 4'hF; wdata = 32'h12345678;
        idle(2);
        rst = 1'b1; ce = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c == 1) rst = 1'b0;
            check("w3 abort no ack", 32'(ack_w3), 32'd0);
        end
        check("w3 abort busy", 32'(busy_w3), 32'd0);
        run_req(3, 1'b0, 32'h20, 4'h0, 32'd0, "w3 rd20", rd);
        check("w3 abort kept old", rd, 32'hCAFEF00D);
        idle(6);

        // Zero wait states, ce held high, alternating write/read at 0x40.
        wv[0] = 32'h11111111;
        wv[1] = 32'hA5A55A5A;
        wv[2] = 32'h0BADF00D;
        @(negedge clk);
        ce = 1'b1; we = 1'b1; addr = 32'h40; sel = 4'hF; wdata = wv[0];
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(negedge clk);
            check($sformatf("w0 ack cyc%0d", cyc), 32'(ack_w0), 32'(cyc % 2));
            if (ack_w0 && (cyc % 2 == 1)) begin
                int k;
                k = (cyc - 1) / 2;
                if (k % 2 == 1) check($sformatf("w0 rd op%0d", k), dout_w0, wv[k/2]);
                else if (k > 0) check($sformatf("w0 wr hold op%0d", k), dout_w0, wv[k/2 - 1]);
                if (k + 1 < 6) begin
                    we = ((k + 1) % 2 == 0);
                    wdata = wv[(k + 1) / 2];
                end else begin
                    ce = 1'b0;
                end
            end
        end
        ce = 1'b0;
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
